// File: rtl/instr_fetch_unit_if.sv
// Interface bundle for instr_fetch_unit: instruction-memory port plus the
// decode-side handshake, redirect input and halt status.
// master: the fetch unit. slave: memory / decode / datapath environment.
interface instr_fetch_unit_if;
    // Instruction memory port
    logic        iREN;
    logic [31:0] iaddr;
    logic        ihit;
    logic [31:0] iload;

    // Decode handshake
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;

    // Datapath redirect and status
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        halted;

    modport master (
        output iREN, iaddr, instr, instr_pc, instr_valid, halted,
        input  ihit, iload, instr_ready, redirect, redirect_pc
    );

    modport slave (
        input  iREN, iaddr, instr, instr_pc, instr_valid, halted,
        output ihit, iload, instr_ready, redirect, redirect_pc
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: owns the PC, prefetches instruction words into a small
// FIFO and hands them to decode over a valid/ready handshake. Redirects from
// the datapath flush the FIFO and restart fetch; a popped HALT stops fetch
// until reset.
// Optional build macro FETCH_PERF_EN adds stall_cnt / flush_cnt counters.
module instr_fetch_unit #(
    parameter logic [31:0] PC_INIT   = 32'h0000_0000,
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic                CLK,
    input  logic                nRST,
    instr_fetch_unit_if.master  bus
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]         stall_cnt,
    output logic [31:0]         flush_cnt
`endif
);

    localparam int unsigned PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(BUF_DEPTH);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] FETCH  = 2'd1;
    localparam logic [1:0] HALTED = 2'd2;

    localparam logic [5:0] HALT_OP = 6'b111111;

    logic [1:0]        state;
    logic [31:0]       pc;
    logic [31:0]       buf_instr [BUF_DEPTH];
    logic [31:0]       buf_pc    [BUF_DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count;

    logic              in_fetch;
    logic              has_room;
    logic              req;
    logic              push;
    logic              pop;
    logic              halt_pop;
    logic              do_redirect;
    logic [31:0]       head_instr;
    logic [31:0]       head_pc;
    logic              head_valid;

    // Request / handshake qualifiers
    always_comb begin
        in_fetch    = (state == FETCH);
        has_room    = (count < DEPTH_CNT);
        req         = in_fetch && has_room && !bus.redirect;
        push        = req && bus.ihit;
        head_valid  = (count != '0);
        head_instr  = buf_instr[rd_ptr];
        head_pc     = buf_pc[rd_ptr];
        pop         = head_valid && bus.instr_ready;
        halt_pop    = in_fetch && pop && (head_instr[31:26] == HALT_OP);
        // A HALT pop wins over a simultaneous redirect.
        do_redirect = in_fetch && bus.redirect && !halt_pop;
    end

    // Outputs toward memory and decode; head fields read as zero when empty
    always_comb begin
        bus.iREN        = req;
        bus.iaddr       = pc;
        bus.instr_valid = head_valid;
        bus.instr       = head_valid ? head_instr : '0;
        bus.instr_pc    = head_valid ? head_pc    : '0;
        bus.halted      = (state == HALTED);
    end

    // Fetch control FSM: IDLE -> FETCH -> HALTED (left only by reset)
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    state <= FETCH;
                FETCH:   if (halt_pop) state <= HALTED;
                HALTED:  state <= HALTED;
                default: state <= IDLE;
            endcase
        end
    end

    // PC and FIFO bookkeeping: halt flush > redirect flush > push/pop
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            pc     <= PC_INIT;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (halt_pop) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (do_redirect) begin
            pc     <= bus.redirect_pc & 32'hFFFF_FFFC;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                pc     <= pc + 32'd4;
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // FIFO storage; contents are don't-care while the slot is not counted
    always_ff @(posedge CLK) begin
        if (push) begin
            buf_instr[wr_ptr] <= bus.iload;
            buf_pc[wr_ptr]    <= pc;
        end
    end

`ifdef FETCH_PERF_EN
    // Saturating performance counters, active only while fetching
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (in_fetch && !head_valid && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            if (do_redirect && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios plus random
// traffic, all compared against a queue-based reference model of the fetch
// rules (PC stream, prefetch queue, redirect flush, halt).
module tb_instr_fetch_unit;

    localparam logic [31:0] PC_INIT = 32'h0000_0000;
    localparam int          DEPTH   = 2;

    logic CLK;
    logic nRST;

    instr_fetch_unit_if bus ();

`ifdef FETCH_PERF_EN
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;
`endif

    instr_fetch_unit #(
        .PC_INIT   (PC_INIT),
        .BUF_DEPTH (DEPTH)
    ) dut (
        .CLK       (CLK),
        .nRST      (nRST),
        .bus       (bus)
`ifdef FETCH_PERF_EN
        ,
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [31:0] w;
        logic [31:0] a;
    } ent_t;

    // Reference model state
    ent_t        q[$];
    logic [31:0] m_pc;
    logic        m_started;
    logic        m_halted;
    logic [31:0] m_stall;
    logic [31:0] m_flush;
    logic [31:0] halt_addr;

    int n_cmp;
    int n_bad;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Instruction memory contents: pseudo-random words that are never HALT,
    // except at halt_addr.
    function automatic logic [31:0] memword(input logic [31:0] a);
        logic [31:0] w;
        if (a == halt_addr) return 32'hFC00_0000;
        w = (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
        if (w[31:26] == 6'b111111) w[31] = 1'b0;
        return w;
    endfunction

    task automatic model_reset();
        q.delete();
        m_pc      = PC_INIT;
        m_started = 1'b0;
        m_halted  = 1'b0;
        m_stall   = '0;
        m_flush   = '0;
    endtask

    // One clock cycle: called at a negedge, drives inputs, checks outputs,
    // advances the model at the posedge and returns at the next negedge.
    task automatic step(input logic hit, input logic rdy, input logic redir, input logic [31:0] rpc);
        logic ex_iren;
        logic popv;
        logic halt;
        logic fetching;
        bus.ihit        = hit;
        bus.instr_ready = rdy;
        bus.redirect    = redir;
        bus.redirect_pc = rpc;
        bus.iload       = memword(m_pc);
        #1;
        fetching = m_started && !m_halted;
        ex_iren  = fetching && (q.size() < DEPTH) && !redir;
        check("iREN", {31'd0, bus.iREN}, {31'd0, ex_iren});
        if (!m_halted) check("iaddr", bus.iaddr, m_pc);
        check("instr_valid", {31'd0, bus.instr_valid}, {31'd0, q.size() > 0});
        check("instr", bus.instr, (q.size() > 0) ? q[0].w : 32'd0);
        check("instr_pc", bus.instr_pc, (q.size() > 0) ? q[0].a : 32'd0);
        check("halted", {31'd0, bus.halted}, {31'd0, m_halted});
`ifdef FETCH_PERF_EN
        check("stall_cnt", stall_cnt, m_stall);
        check("flush_cnt", flush_cnt, m_flush);
`endif
        @(posedge CLK);
        if (!m_started) begin
            m_started = 1'b1;
        end else if (!m_halted) begin
            popv = (q.size() > 0) && rdy;
            halt = popv && (q[0].w[31:26] == 6'b111111);
            if (q.size() == 0 && m_stall != 32'hFFFF_FFFF) m_stall++;
            if (halt) begin
                m_halted = 1'b1;
                q.delete();
            end else if (redir) begin
                if (m_flush != 32'hFFFF_FFFF) m_flush++;
                q.delete();
                m_pc = {rpc[31:2], 2'b00};
            end else begin
                if (popv) void'(q.pop_front());
                if (ex_iren && hit) begin
                    q.push_back({memword(m_pc), m_pc});
                    m_pc = m_pc + 32'd4;
                end
            end
        end
        @(negedge CLK);
    endtask

    // Hold reset for one cycle, checking the asynchronous reset values.
    task automatic do_reset();
        nRST            = 1'b0;
        bus.ihit        = 1'b0;
        bus.instr_ready = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;
        bus.iload       = '0;
        model_reset();
        #1;
        check("rst_iREN", {31'd0, bus.iREN}, 32'd0);
        check("rst_iaddr", bus.iaddr, PC_INIT);
        check("rst_valid", {31'd0, bus.instr_valid}, 32'd0);
        check("rst_instr", bus.instr, 32'd0);
        check("rst_instr_pc", bus.instr_pc, 32'd0);
        check("rst_halted", {31'd0, bus.halted}, 32'd0);
        @(negedge CLK);
        nRST = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        halt_addr = 32'hFFFF_FFFF;
        nRST      = 1'b0;
        @(negedge CLK);
        do_reset();

        // Straight line: ihit alongside iREN, decode always ready
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0, '0);

        // Backpressure: FIFO fills to DEPTH then drains in order
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0, '0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, '0);

        // Redirect with an ihit in the same cycle
        step(1'b1, 1'b0, 1'b0, '0);
        step(1'b1, 1'b0, 1'b1, 32'h0000_0103);
        check("redir_iaddr", bus.iaddr, 32'h0000_0100);
        check("redir_empty", {31'd0, bus.instr_valid}, 32'd0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, '0);

        // PC wrap at the top of the address space
        step(1'b0, 1'b1, 1'b1, 32'hFFFF_FFF9);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, '0);

        // Reset mid-request with a valid head entry
        step(1'b1, 1'b0, 1'b0, '0);
        nRST = 1'b0;
        #1;
        check("midrst_iREN", {31'd0, bus.iREN}, 32'd0);
        check("midrst_valid", {31'd0, bus.instr_valid}, 32'd0);
        @(negedge CLK);
        do_reset();

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            logic [31:0] rpc;
            rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                               : $urandom;
            step($urandom_range(0, 99) < 60, $urandom_range(0, 99) < 70,
                 $urandom_range(0, 99) < 6, rpc);
        end

        // Halt: HALT word at address 8
        do_reset();
        halt_addr = 32'h0000_0008;
        for (int i = 0; i < 40 && !m_halted; i++) step(1'b1, 1'b1, 1'b0, '0);
        check("halt_reached", {31'd0, bus.halted}, 32'd1);
        for (int i = 0; i < 20; i++) step($urandom_range(0, 1) == 1, 1'b1, 1'b1, $urandom);

        // Reset restores fetch from PC_INIT
        halt_addr = 32'hFFFF_FFFF;
        do_reset();
        for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
